// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and small decode helpers.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative mul/div unit: accepts a start, spends one cycle
// preparing operand magnitudes, runs WIDTH iterations, then a fix-up cycle.
module muldiv_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    output logic o_accept,
    output logic o_load,
    output logic o_run,
    output logic o_fin,
    output logic o_busy,
    output logic o_done
);

    state_e            r_state, w_state_nxt;
    logic [CNTW-1:0]   r_cnt, w_cnt_nxt;
    logic              r_pend;
    logic              r_done;
    logic              w_idle;

    assign w_idle   = (r_state == IDLE);
    assign o_accept = w_idle & ~r_pend & i_start;
    assign o_load   = w_idle & r_pend;
    assign o_run    = (r_state == RUN);
    assign o_fin    = (r_state == FIN);
    assign o_busy   = o_run | o_fin;
    assign o_done   = r_done;

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (r_pend) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = CNTW'(WIDTH);
                end
            end
            RUN: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CNTW'(1)) begin
                    w_state_nxt = FIN;
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= o_accept;
            r_done  <= o_fin;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit with architectural HI/LO registers:
// shift-add multiply and restoring divide on magnitudes, sign fix-up at the end.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNTW = $clog2(WIDTH) + 1;

    logic w_accept, w_load, w_run, w_fin;

    muldiv_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .i_start  (start),
        .o_accept (w_accept),
        .o_load   (w_load),
        .o_run    (w_run),
        .o_fin    (w_fin),
        .o_busy   (busy),
        .o_done   (done)
    );

    op_e                r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_m, r_hi, r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_div0;

    logic               w_is_div, w_sa, w_sb, w_div0;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_res_hi, w_res_lo;
    logic [WIDTH:0]     w_sum, w_trial;
    logic [2*WIDTH-1:0] w_acc_step, w_prod;

    // Sign flags and magnitudes come from the latched raw operands, which stay stable for the whole op.
    assign w_is_div = op_is_div(r_op);
    assign w_sa     = op_is_signed(r_op) & r_a[WIDTH-1];
    assign w_sb     = op_is_signed(r_op) & r_b[WIDTH-1];
    assign w_mag_a  = w_sa ? -r_a : r_a;
    assign w_mag_b  = w_sb ? -r_b : r_b;
    assign w_div0   = w_is_div & (r_b == '0);

    // Multiply keeps {partial_hi, multiplier} in r_acc; divide keeps {remainder, dividend/quotient}.
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_m};

    always_comb begin
        if (!w_is_div) begin
            w_acc_step = {w_sum, r_acc[WIDTH-1:1]};
        end else if (w_trial[WIDTH]) begin
            w_acc_step = {r_acc[2*WIDTH-2:0], 1'b0};
        end else begin
            w_acc_step = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
    end

    assign w_prod = (w_sa ^ w_sb) ? -r_acc : r_acc;
    assign w_quo  = (w_sa ^ w_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = w_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    assign w_res_hi = !w_is_div ? w_prod[2*WIDTH-1:WIDTH] : (w_div0 ? r_a : w_rem);
    assign w_res_lo = !w_is_div ? w_prod[WIDTH-1:0]       : (w_div0 ? '1  : w_quo);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op <= OP_MULT;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept) begin
            r_op <= op_e'(op);
            r_a  <= a;
            r_b  <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m   <= '0;
            r_acc <= '0;
        end else if (w_load) begin
            r_m   <= w_is_div ? w_mag_b : w_mag_a;
            r_acc <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
        end else if (w_run) begin
            r_acc <= w_acc_step;
        end
    end

    // Direct writes are honoured only while idle; the done cycle is idle, so mthi/mtlo there wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_div0 <= 1'b0;
        end else begin
            r_div0 <= w_fin & w_div0;
            if (w_fin) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (!busy) begin
                if (hi_we) r_hi <= wd;
                if (lo_we) r_lo <= wd;
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign div0 = r_div0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: an edge-indexed arithmetic model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_muldiv_unit;
    import mips_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] a, b, wd;
    logic         busy, done, div0;
    logic [W-1:0] hi, lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic void model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rd);
        longint      sx, sy, p, q, r;
        logic [63:0] pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rd = 1'b0;
        rh = '0;
        rl = '0;
        case (o)
            2'b00: begin p = sx * sy; pu = p; rh = pu[63:32]; rl = pu[31:0]; end
            2'b01: begin pu = {32'b0, x} * {32'b0, y}; rh = pu[63:32]; rl = pu[31:0]; end
            2'b10: begin
                if (y == 0) begin
                    rh = x; rl = '1; rd = 1'b1;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    rh = '0; rl = x;
                end else begin
                    q = sx / sy; r = sx % sy;
                    pu = q; rl = pu[31:0];
                    pu = r; rh = pu[31:0];
                end
            end
            default: begin
                if (y == 0) begin
                    rh = x; rl = '1; rd = 1'b1;
                end else begin
                    rl = x / y; rh = x % y;
                end
            end
        endcase
    endfunction

    // Model state indexed by rising-edge number.
    int           edge_n = 0;
    int           m_e    = 0;
    bit           m_fly  = 1'b0;
    bit           chk_on = 1'b0;
    bit           was_fly, idle_before;
    logic [W-1:0] m_hi, m_lo, mr_hi, mr_lo;
    logic         mr_div0;
    logic         e_busy, e_done, e_div0;

    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            m_fly  = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_div0 = 1'b0;
        end else begin
            was_fly     = m_fly;
            idle_before = !(m_fly && (edge_n - 1 >= m_e + 1) && (edge_n - 1 <= m_e + W + 1));
            e_done      = 1'b0;
            e_div0      = 1'b0;
            if (m_fly && edge_n == m_e + W + 2) begin
                m_hi   = mr_hi;
                m_lo   = mr_lo;
                e_done = 1'b1;
                e_div0 = mr_div0;
                m_fly  = 1'b0;
            end else if (idle_before) begin
                if (hi_we) m_hi = wd;
                if (lo_we) m_lo = wd;
            end
            if (!was_fly && start) begin
                m_fly = 1'b1;
                m_e   = edge_n;
                model_op(op, a, b, mr_hi, mr_lo, mr_div0);
            end
            e_busy = m_fly && (edge_n >= m_e + 1) && (edge_n <= m_e + W + 1);
        end
        chk_on = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_busy", 64'(busy), 64'(e_busy));
            check("cyc_done", 64'(done), 64'(e_done));
            check("cyc_div0", 64'(div0), 64'(e_div0));
            check("cyc_hi",   64'(hi),   64'(m_hi));
            check("cyc_lo",   64'(lo),   64'(m_lo));
        end
    end

    // Drive a start for one cycle, then scramble the operand inputs.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = ~o;
        a     = ~x;
        b     = $urandom;
    endtask

    // k0: cycles elapsed since the start edge at call time; nb0: busy cycles seen before cycle k0.
    task automatic finish_op(input string name, input int k0, input int nb0,
                             input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
        int k;
        int nb;
        k  = k0;
        nb = nb0 + (busy === 1'b1 ? 1 : 0);
        while (done !== 1'b1 && k < k0 + 80) begin
            @(negedge clk);
            k++;
            if (busy === 1'b1) nb++;
        end
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_lat"},  64'(k),    64'(W + 3));
        check({name, "_busy"}, 64'(nb),   64'(W + 1));
        check({name, "_hi"},   64'(hi),   64'(eh));
        check({name, "_lo"},   64'(lo),   64'(el));
        check({name, "_div0"}, 64'(div0), 64'(ed));
    endtask

    bit seen_done;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wd    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        reset = 1'b0;
        @(negedge clk);

        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max", 1, 0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

        launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        finish_op("mult_neg", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_b2b", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        launch(OP_DIVU, 32'd100, 32'd0);
        finish_op("divu_zero", 1, 0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        check("div0_pulse", 64'(div0), 64'd0);
        launch(OP_DIVU, 32'd100, 32'd7);
        finish_op("divu_100_7", 1, 0, 32'd2, 32'd14, 1'b0);

        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", 1, 0, 32'd0, 32'h8000_0000, 1'b0);
        launch(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        finish_op("div_7_m2", 1, 0, 32'd1, 32'hFFFF_FFFD, 1'b0);
        launch(OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        finish_op("div_m7_m2", 1, 0, 32'hFFFF_FFFF, 32'd3, 1'b0);

        // Stray start and mthi in the middle of a run must not disturb it.
        launch(OP_MULTU, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        op    = OP_DIV;
        a     = 32'd1;
        b     = 32'd1;
        start = 1'b1;
        hi_we = 1'b1;
        wd    = 32'h55;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        finish_op("multu_ign", 11, 9, 32'd0, 32'd42, 1'b0);
        hi_we = 1'b1;
        wd    = 32'h55;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_idle", 64'(hi), 64'h55);
        check("mthi_lo",   64'(lo), 64'd42);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wd    = 32'hAA;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthilo_hi", 64'(hi), 64'hAA);
        check("mthilo_lo", 64'(lo), 64'hAA);

        // Synchronous reset during RUN cycle 15 aborts without a done pulse.
        launch(OP_MULTU, 32'd6, 32'd7);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi",   64'(hi),   64'd0);
        check("abort_lo",   64'(lo),   64'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("abort_nodone", 64'(seen_done), 64'd0);
        launch(OP_MULT, 32'd5, 32'hFFFF_FFFC);
        finish_op("mult_after", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
